// File: rtl/seven_segment_counter_display_n_if.sv
// Board-side bundle for the seven-segment counter: control/config inputs, counter status and display pins.
// The master modport is the board/controller side, the slave modport is the counter/display block.
interface seven_segment_counter_display_n_if #(
    parameter int Digit_Count      = 4,
    parameter int Count_Width      = 14,
    parameter int Brightness_Width = 4
);
    logic                        clk_en;
    logic [31:0]                 clk_pps;
    logic                        increment;
    logic                        decrement;
    logic                        clear;
    logic                        mode_saturate;
    logic                        blank_zeros;
    logic [Digit_Count-1:0]      dp_mask;
    logic [Brightness_Width-1:0] brightness;
    logic [Count_Width-1:0]      count_value;
    logic                        limit_pulse;
    logic                        bcd_valid;
    logic [7:0]                  segments_n;
    logic [Digit_Count-1:0]      digit_select_n;

    modport master (
        output clk_en, clk_pps, increment, decrement, clear, mode_saturate,
               blank_zeros, dp_mask, brightness,
        input  count_value, limit_pulse, bcd_valid, segments_n, digit_select_n
    );

    modport slave (
        input  clk_en, clk_pps, increment, decrement, clear, mode_saturate,
               blank_zeros, dp_mask, brightness,
        output count_value, limit_pulse, bcd_valid, segments_n, digit_select_n
    );
endinterface

// File: rtl/seven_segment_counter_display_n.sv
// N-digit up/down counter with sequential double-dabble BCD conversion driving a multiplexed,
// PWM-dimmed common-anode 7-segment bank with leading-zero blanking and ghost blanking.
module seven_segment_counter_display_n #(
    parameter int Digit_Count      = 4,
    parameter int Count_Max        = 9999,
    parameter int Count_Width      = 14,
    parameter int Dwell_Shift      = 12,
    parameter int Brightness_Width = 4
) (
    input logic clk,
    input logic async_rst_n,
    seven_segment_counter_display_n_if.slave bus
);
    localparam int BcdWidth      = 4 * Digit_Count;
    localparam int IdxWidth      = (Digit_Count > 1) ? $clog2(Digit_Count) : 1;
    localparam int ShiftCntWidth = $clog2(Count_Width + 1);

    localparam logic [Count_Width-1:0]   CountMax  = Count_Width'(Count_Max);
    localparam logic [ShiftCntWidth-1:0] LastShift = ShiftCntWidth'(Count_Width - 1);
    localparam logic [IdxWidth-1:0]      LastIdx   = IdxWidth'(Digit_Count - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [Count_Width-1:0]      count_q, count_d;
    logic                        limit_pulse_q, limit_pulse_d;
    logic [1:0]                  state_q, state_d;
    logic [Count_Width-1:0]      snap_q, snap_d;
    logic [Count_Width-1:0]      bin_q, bin_d;
    logic [BcdWidth-1:0]         scratch_q, scratch_d;
    logic [ShiftCntWidth-1:0]    shift_cnt_q, shift_cnt_d;
    logic [BcdWidth-1:0]         bcd_q, bcd_d;
    logic                        bcd_valid_q, bcd_valid_d;
    logic [31:0]                 dwell_cnt_q, dwell_cnt_d;
    logic [31:0]                 dwell_last_q, dwell_last_d;
    logic [IdxWidth-1:0]         idx_q, idx_d;
    logic [Brightness_Width-1:0] pwm_q, pwm_d;
    logic [7:0]                  segments_n_q, segments_n_d;
    logic [Digit_Count-1:0]      digit_select_n_q, digit_select_n_d;

    logic [31:0]                     pps_div;
    logic [BcdWidth-1:0]             adj;
    logic [BcdWidth+Count_Width-1:0] shifted;
    logic                            lead_zero;
    logic [3:0]                      cur_nib;
    logic                            cur_dp;
    logic                            cur_blank;
    logic                            anode_on;

    // Active-low {g,f,e,d,c,b,a} patterns for the decimal digits; anything else is blank.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d and helper gets a default first so no path can infer a latch.
        count_d          = count_q;
        limit_pulse_d    = limit_pulse_q;
        state_d          = state_q;
        snap_d           = snap_q;
        bin_d            = bin_q;
        scratch_d        = scratch_q;
        shift_cnt_d      = shift_cnt_q;
        bcd_d            = bcd_q;
        bcd_valid_d      = bcd_valid_q;
        dwell_cnt_d      = dwell_cnt_q;
        dwell_last_d     = dwell_last_q;
        idx_d            = idx_q;
        pwm_d            = pwm_q;
        segments_n_d     = segments_n_q;
        digit_select_n_d = digit_select_n_q;

        pps_div = bus.clk_pps >> Dwell_Shift;

        adj = scratch_q;
        for (int i = 0; i < Digit_Count; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        shifted = {adj, bin_q} << 1;

        lead_zero = 1'b1;
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int i = Digit_Count - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (bcd_q[4*i +: 4] == 4'd0);
            if (idx_q == IdxWidth'(i)) begin
                cur_nib   = bcd_q[4*i +: 4];
                cur_dp    = bus.dp_mask[i];
                cur_blank = !bcd_valid_q || (bus.blank_zeros && (i != 0) && lead_zero);
            end
        end
        anode_on = (dwell_cnt_q != 32'd0) && (pwm_q < bus.brightness);

        if (bus.clk_en) begin
            limit_pulse_d = 1'b0;
            if (bus.clear) begin
                count_d = '0;
            end else if (bus.decrement && !bus.increment) begin
                if (count_q == '0) begin
                    limit_pulse_d = 1'b1;
                    if (!bus.mode_saturate) count_d = CountMax;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end else if (bus.increment && !bus.decrement) begin
                if (count_q == CountMax) begin
                    limit_pulse_d = 1'b1;
                    if (!bus.mode_saturate) count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            // The display keeps the old BCD until a whole conversion lands in DONE.
            case (state_q)
                S_IDLE: begin
                    if (count_q != snap_q) state_d = S_LOAD;
                end
                S_LOAD: begin
                    snap_d      = count_q;
                    bin_d       = count_q;
                    scratch_d   = '0;
                    shift_cnt_d = '0;
                    state_d     = S_SHIFT;
                end
                S_SHIFT: begin
                    scratch_d   = shifted[BcdWidth+Count_Width-1 -: BcdWidth];
                    bin_d       = shifted[Count_Width-1:0];
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    if (shift_cnt_q == LastShift) state_d = S_DONE;
                end
                default: begin
                    bcd_d       = scratch_q;
                    bcd_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            endcase

            // Dwell length is latched on the first cycle of each dwell, so clk_pps edits wait a boundary.
            if (dwell_cnt_q == 32'd0) begin
                dwell_last_d = (pps_div < 32'd2) ? 32'd1 : pps_div - 32'd1;
                dwell_cnt_d  = 32'd1;
            end else if (dwell_cnt_q >= dwell_last_q) begin
                dwell_cnt_d = 32'd0;
                idx_d       = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 32'd1;
            end
            pwm_d = pwm_q + 1'b1;

            segments_n_d     = {~cur_dp, cur_blank ? 7'b1111111 : glyph(cur_nib)};
            digit_select_n_d = anode_on ? ~(Digit_Count'(1) << idx_q) : '1;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            count_q          <= '0;
            limit_pulse_q    <= 1'b0;
            state_q          <= S_IDLE;
            snap_q           <= '0;
            bin_q            <= '0;
            scratch_q        <= '0;
            shift_cnt_q      <= '0;
            bcd_q            <= '0;
            bcd_valid_q      <= 1'b0;
            dwell_cnt_q      <= 32'd0;
            dwell_last_q     <= 32'd0;
            idx_q            <= '0;
            pwm_q            <= '0;
            segments_n_q     <= '1;
            digit_select_n_q <= '1;
        end else begin
            count_q          <= count_d;
            limit_pulse_q    <= limit_pulse_d;
            state_q          <= state_d;
            snap_q           <= snap_d;
            bin_q            <= bin_d;
            scratch_q        <= scratch_d;
            shift_cnt_q      <= shift_cnt_d;
            bcd_q            <= bcd_d;
            bcd_valid_q      <= bcd_valid_d;
            dwell_cnt_q      <= dwell_cnt_d;
            dwell_last_q     <= dwell_last_d;
            idx_q            <= idx_d;
            pwm_q            <= pwm_d;
            segments_n_q     <= segments_n_d;
            digit_select_n_q <= digit_select_n_d;
        end
    end

    assign bus.count_value    = count_q;
    assign bus.limit_pulse    = limit_pulse_q;
    assign bus.bcd_valid      = bcd_valid_q;
    assign bus.segments_n     = segments_n_q;
    assign bus.digit_select_n = digit_select_n_q;
endmodule

// File: tb/tb_seven_segment_counter_display_n.sv
// Randomised self-checking bench for seven_segment_counter_display_n, scored against an
// arithmetic model of the counter, the scan/PWM timing and the decimal glyphs.
module tb_seven_segment_counter_display_n;
    localparam int DIGITS = 4;
    localparam int CW     = 14;
    localparam int BW     = 4;
    localparam int MAXV   = 9999;

    logic clk = 1'b0;
    logic async_rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Model state: counter, clk_en edges since reset, expected registered outputs.
    int         m_count;
    bit         m_pulse;
    int         m_k;
    int         m_idx;
    logic [3:0] m_sel;
    logic [7:0] m_seg;
    int         m_shown;  // -2: no conversion yet (blank), -1: display in flux, else settled value

    logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seven_segment_counter_display_n_if #(
        .Digit_Count(DIGITS), .Count_Width(CW), .Brightness_Width(BW)
    ) bus ();

    seven_segment_counter_display_n #(
        .Digit_Count(DIGITS), .Count_Max(MAXV), .Count_Width(CW),
        .Dwell_Shift(10), .Brightness_Width(BW)
    ) dut (
        .clk(clk), .async_rst_n(async_rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int shown, input int idx, input bit bz,
                                           input logic [3:0] dp);
        int p;
        logic [6:0] g;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (shown < 0) g = 7'h7F;
        else if (bz && idx > 0 && shown < p) g = 7'h7F;
        else g = glyph_tab[(shown / p) % 10];
        return {~dp[idx], g};
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_pulse = 1'b0;
        m_k     = 0;
        m_idx   = 0;
        m_sel   = 4'hF;
        m_seg   = 8'hFF;
        m_shown = -2;
    endtask

    // One clock: inputs are stable from the previous negedge, model advances at posedge, check at negedge.
    task automatic step();
        int prev, dwell, dw, pwm;
        @(posedge clk);
        if (async_rst_n && bus.clk_en) begin
            prev    = m_count;
            m_pulse = 1'b0;
            if (bus.clear) begin
                m_count = 0;
            end else if (bus.increment && !bus.decrement) begin
                if (m_count == MAXV) begin
                    m_pulse = 1'b1;
                    if (!bus.mode_saturate) m_count = 0;
                end else m_count = m_count + 1;
            end else if (bus.decrement && !bus.increment) begin
                if (m_count == 0) begin
                    m_pulse = 1'b1;
                    if (!bus.mode_saturate) m_count = MAXV;
                end else m_count = m_count - 1;
            end
            if (m_count != prev) m_shown = -1;
            dwell = int'(bus.clk_pps >> 10);
            if (dwell < 2) dwell = 2;
            dw    = m_k % dwell;
            m_idx = (m_k / dwell) % DIGITS;
            pwm   = m_k % (1 << BW);
            m_sel = (dw != 0 && pwm < int'(bus.brightness)) ? ~(4'b0001 << m_idx) : 4'hF;
            m_seg = exp_seg(m_shown, m_idx, bus.blank_zeros, bus.dp_mask);
            m_k   = m_k + 1;
        end
        cyc++;
        @(negedge clk);
        check("count_value", bus.count_value, m_count);
        check("limit_pulse", bus.limit_pulse, m_pulse);
        check("digit_select_n", bus.digit_select_n, m_sel);
        if (m_shown != -1) check("bcd_valid", bus.bcd_valid, m_shown >= 0);
        if (m_shown != -1 && m_sel != 4'hF) check("segments_n", bus.segments_n, m_seg);
    endtask

    task automatic op(input bit inc, input bit dec, input bit clr);
        bus.increment = inc;
        bus.decrement = dec;
        bus.clear     = clr;
        step();
        bus.increment = 1'b0;
        bus.decrement = 1'b0;
        bus.clear     = 1'b0;
        step();
    endtask

    task automatic show(input int n);
        m_shown = m_count;
        repeat (n) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, bus.count_value, 0);
        check({tag, "_pulse"}, bus.limit_pulse, 0);
        check({tag, "_valid"}, bus.bcd_valid, 0);
        check({tag, "_seg"}, bus.segments_n, 8'hFF);
        check({tag, "_sel"}, bus.digit_select_n, 4'hF);
    endtask

    initial begin
        int lat;
        bit seen, ok;
        async_rst_n        = 1'b1;
        bus.clk_en         = 1'b1;
        bus.clk_pps        = 32'd4096;
        bus.increment      = 1'b0;
        bus.decrement      = 1'b0;
        bus.clear          = 1'b0;
        bus.mode_saturate  = 1'b0;
        bus.blank_zeros    = 1'b1;
        bus.dp_mask        = 4'b0000;
        bus.brightness     = 4'd15;
        #2 async_rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        async_rst_n = 1'b1;

        // Scan with nothing converted yet: 4-cycle dwells, blank first cycle, all segments off.
        repeat (16) step();

        // 12 increments from reset; first conversion lands exactly Count_Width+3 cycles after the first change.
        lat  = -1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.increment = (i < 12);
            step();
            if (!seen && bus.bcd_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        bus.increment = 1'b0;
        check("bcd_latency", lat, 17);
        show(16);
        bus.blank_zeros = 1'b0;
        show(16);
        bus.blank_zeros = 1'b1;
        bus.dp_mask     = 4'b1100;
        show(16);
        bus.dp_mask     = 4'b0000;

        // Boundaries in wrap and saturate modes.
        bus.mode_saturate = 1'b0;
        op(1'b1, 1'b0, 1'b1);
        op(1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 1'b0);
        op(1'b0, 1'b1, 1'b0);
        bus.mode_saturate = 1'b1;
        op(1'b1, 1'b0, 1'b0);
        repeat (40) step();
        show(16);
        op(1'b0, 1'b0, 1'b1);
        op(1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b1, 1'b0);
        op(1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b1, 1'b0);

        // Random traffic, including clk_en gaps and brightness/mode changes.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.clear         = (r < 3);
            bus.increment     = (r >= 3 && r < 40) || (r >= 75 && r < 80);
            bus.decrement     = (r >= 40 && r < 80);
            bus.mode_saturate = ($urandom_range(0, 3) == 0);
            bus.clk_en        = ($urandom_range(0, 9) != 0);
            bus.brightness    = 4'($urandom_range(0, 15));
            bus.blank_zeros   = 1'($urandom_range(0, 1));
            bus.dp_mask       = 4'($urandom_range(0, 15));
            step();
        end
        bus.clear      = 1'b0;
        bus.increment  = 1'b0;
        bus.decrement  = 1'b0;
        bus.clk_en     = 1'b1;
        bus.brightness = 4'd15;
        repeat (45) step();
        show(32);

        // PWM extremes.
        bus.brightness = 4'd0;
        repeat (32) step();
        bus.brightness = 4'd8;
        repeat (32) step();
        bus.brightness = 4'd15;

        // Burst during SHIFT: digit 0 may show 0, 1 (complete conversion) or 3, never 2.
        bus.mode_saturate = 1'b0;
        bus.blank_zeros   = 1'b0;
        bus.dp_mask       = 4'b0000;
        op(1'b0, 1'b0, 1'b1);
        repeat (40) step();
        show(16);
        op(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        op(1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 45; i++) begin
            step();
            if (m_sel != 4'hF) begin
                if (m_idx == 0)
                    ok = (bus.segments_n == 8'hC0) || (bus.segments_n == 8'hF9) || (bus.segments_n == 8'hB0);
                else
                    ok = (bus.segments_n == 8'hC0);
                check("burst_digit", ok, 1'b1);
            end
        end
        show(16);

        // clk_en low: requests ignored, every output frozen.
        bus.clk_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.increment = 1'($urandom_range(0, 1));
            bus.decrement = 1'($urandom_range(0, 1));
            bus.clear     = 1'($urandom_range(0, 1));
            step();
        end
        bus.increment = 1'b0;
        bus.decrement = 1'b0;
        bus.clear     = 1'b0;
        bus.clk_en    = 1'b1;
        step();

        // Asynchronous reset in the middle of a conversion.
        op(1'b1, 1'b0, 1'b0);
        repeat (6) step();
        #2 async_rst_n = 1'b0;
        #1 check_reset_outputs("midshift");
        model_reset();
        @(negedge clk);
        async_rst_n = 1'b1;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
